// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Comparator flags packed as {gt, lt, eq}; a legal response is exactly one of these.
  localparam logic [2:0] FLAG_GT = 3'b100;
  localparam logic [2:0] FLAG_LT = 3'b010;
  localparam logic [2:0] FLAG_EQ = 3'b001;

  // Step counter width: must hold DATAWIDTH+1 without wrapping.
  function automatic int step_w(input int dw);
    return $clog2(dw + 2);
  endfunction

endpackage

// File: rtl/sar_bounds.sv
// Combinational bound update: narrows [lo,hi] around the current probe and
// proposes the next midpoint, flagging any response that cannot be honoured.
module sar_bounds
  import sar_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] lo,
  input  logic [DATAWIDTH-1:0] hi,
  input  logic [DATAWIDTH-1:0] probe,
  input  logic [2:0]           flags,
  output logic [DATAWIDTH-1:0] next_lo,
  output logic [DATAWIDTH-1:0] next_hi,
  output logic [DATAWIDTH-1:0] next_mid,
  output logic                 bound_err
);

  localparam logic [DATAWIDTH-1:0] MAX = '1;
  localparam logic [DATAWIDTH:0]   ONE = (DATAWIDTH + 1)'(1);

  logic [DATAWIDTH:0] lo_ext;
  logic [DATAWIDTH:0] hi_ext;
  logic [DATAWIDTH:0] sum;

  // One extra bit keeps probe+1 and lo+hi exact, so lo>hi and the midpoint never wrap.
  always_comb begin
    lo_ext    = {1'b0, lo};
    hi_ext    = {1'b0, hi};
    bound_err = 1'b0;
    case (flags)
      FLAG_EQ: bound_err = 1'b0;
      FLAG_LT: begin
        lo_ext = {1'b0, probe} + ONE;
        if (probe == MAX) bound_err = 1'b1;
      end
      FLAG_GT: begin
        hi_ext = {1'b0, probe} - ONE;
        if (probe == '0) bound_err = 1'b1;
      end
      default: bound_err = 1'b1;
    endcase
    if (lo_ext > hi_ext) bound_err = 1'b1;
    sum = lo_ext + hi_ext;
  end

  assign next_lo  = lo_ext[DATAWIDTH-1:0];
  assign next_hi  = hi_ext[DATAWIDTH-1:0];
  assign next_mid = DATAWIDTH'(sum >> 1);

endmodule

// File: rtl/sar_search.sv
// Binary-search initiator: drives probe into an external comparator and walks
// the gt/lt/eq responses down to the comparator's hidden operand.
module sar_search
  import sar_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 start,
  input  logic                 gt,
  input  logic                 lt,
  input  logic                 eq,
  output logic [DATAWIDTH-1:0] probe,
  output logic [DATAWIDTH-1:0] result,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int                   STEP_W    = step_w(DATAWIDTH);
  localparam logic [DATAWIDTH-1:0] MAX       = '1;
  localparam logic [DATAWIDTH-1:0] MID0      = MAX >> 1;
  localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(DATAWIDTH);

  state_t                state;
  logic [DATAWIDTH-1:0]  lo;
  logic [DATAWIDTH-1:0]  hi;
  logic [STEP_W-1:0]     step;

  logic [DATAWIDTH-1:0]  next_lo;
  logic [DATAWIDTH-1:0]  next_hi;
  logic [DATAWIDTH-1:0]  next_mid;
  logic                  bound_err;

  sar_bounds #(
    .DATAWIDTH(DATAWIDTH)
  ) u_bounds (
    .lo       (lo),
    .hi       (hi),
    .probe    (probe),
    .flags    ({gt, lt, eq}),
    .next_lo  (next_lo),
    .next_hi  (next_hi),
    .next_mid (next_mid),
    .bound_err(bound_err)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      step   <= '0;
      probe  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= PROBE;
            lo    <= '0;
            hi    <= MAX;
            probe <= MID0;
            step  <= '0;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        PROBE: begin
          // A non-eq answer on the last permitted step means the comparator lied.
          if (bound_err || (!eq && step == LAST_STEP)) begin
            result <= '0;
            err    <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FINISH;
          end else if (eq) begin
            result <= probe;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FINISH;
          end else begin
            lo    <= next_lo;
            hi    <= next_hi;
            probe <= next_mid;
            step  <= step + 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed corner cases, fault-injecting
// comparator modes, async reset abort, random DW=8 targets and exhaustive DW=2.
module tb_sar_search;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // DW=8 instance with a programmable comparator
  logic       start8 = 1'b0;
  logic       gt8, lt8, eq8, busy8, done8, err8;
  logic [7:0] probe8, result8;
  int         b8 = 0, mode8 = 0, pidx8 = 0;

  sar_search #(.DATAWIDTH(8)) dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .start(start8), .gt(gt8), .lt(lt8), .eq(eq8),
    .probe(probe8), .result(result8), .busy(busy8), .done(done8), .err(err8)
  );

  // mode 1: gt=lt=1 on 3rd probe; mode 2: no flag on 1st probe; mode 3: always lt
  always_comb begin
    gt8 = (int'(probe8) > b8);
    lt8 = (int'(probe8) < b8);
    eq8 = (int'(probe8) == b8);
    if (mode8 == 1 && pidx8 == 3) begin gt8 = 1'b1; lt8 = 1'b1; eq8 = 1'b0; end
    if (mode8 == 2 && pidx8 == 1) begin gt8 = 1'b0; lt8 = 1'b0; eq8 = 1'b0; end
    if (mode8 == 3)               begin gt8 = 1'b0; lt8 = 1'b1; eq8 = 1'b0; end
  end

  // DW=2 instance with an honest comparator
  logic       start2 = 1'b0;
  logic       gt2, lt2, eq2, busy2, done2, err2;
  logic [1:0] probe2, result2;
  int         b2 = 0;

  sar_search #(.DATAWIDTH(2)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .start(start2), .gt(gt2), .lt(lt2), .eq(eq2),
    .probe(probe2), .result(result2), .busy(busy2), .done(done2), .err(err2)
  );

  always_comb begin
    gt2 = (int'(probe2) > b2);
    lt2 = (int'(probe2) < b2);
    eq2 = (int'(probe2) == b2);
  end

  int obs_p[16];
  int obs_k;
  int lat;
  int exp_p[16];
  int exp_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: textbook binary search over the integer range 0..2^w-1.
  function automatic void model(input int w, input int b);
    int lo = 0;
    int hi = (1 << w) - 1;
    int m;
    exp_k = 0;
    while (exp_k < 16) begin
      m = (lo + hi) / 2;
      exp_p[exp_k] = m;
      exp_k++;
      if (m == b) break;
      if (m < b) lo = m + 1;
      else hi = m - 1;
    end
  endfunction

  task automatic cmp_seq(input string tag);
    chk({tag, "_nprobes"}, obs_k, exp_k);
    for (int i = 0; i < exp_k && i < obs_k && i < 16; i++)
      chk($sformatf("%s_probe%0d", tag, i), obs_p[i], exp_p[i]);
  endtask

  task automatic run8(input int b, input int mode, input bit poke);
    obs_k = 0;
    lat   = 0;
    @(negedge Clk);
    b8 = b; mode8 = mode; pidx8 = 1; start8 = 1'b1;
    @(negedge Clk);
    start8 = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done8) begin lat = cyc; break; end
      if (obs_k < 16) obs_p[obs_k] = probe8;
      obs_k++;
      chk("busy8_probe", busy8, 1'b1);
      start8 = (poke && cyc == 2);
      @(negedge Clk);
      pidx8++;
    end
    start8 = 1'b0;
    if (lat == 0) chk("timeout8", 0, 1);
  endtask

  task automatic fin8(input string tag, input int exp_res, input int exp_err);
    chk({tag, "_lat"}, lat, obs_k + 1);
    chk({tag, "_done"}, done8, 1'b1);
    chk({tag, "_busy"}, busy8, 1'b0);
    chk({tag, "_result"}, result8, exp_res);
    chk({tag, "_err"}, err8, exp_err);
    if (obs_k > 0 && obs_k <= 16) chk({tag, "_hold"}, probe8, obs_p[obs_k-1]);
    @(negedge Clk);
    chk({tag, "_done_pulse"}, done8, 1'b0);
    if (obs_k > 0 && obs_k <= 16) chk({tag, "_hold_idle"}, probe8, obs_p[obs_k-1]);
    $display("txn %s: probes=%0d latency=%0d result=%0d err=%0d", tag, obs_k, lat, result8, err8);
  endtask

  task automatic run2(input int b);
    obs_k = 0;
    lat   = 0;
    @(negedge Clk);
    b2 = b; start2 = 1'b1;
    @(negedge Clk);
    start2 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done2) begin lat = cyc; break; end
      if (obs_k < 16) obs_p[obs_k] = probe2;
      obs_k++;
      @(negedge Clk);
    end
    if (lat == 0) chk("timeout2", 0, 1);
    chk("dw2_done", done2, 1'b1);
    chk("dw2_result", result2, b);
    chk("dw2_err", err2, 1'b0);
    chk("dw2_bound", (obs_k <= 3), 1'b1);
    chk("dw2_lat", lat, obs_k + 1);
    $display("txn dw2 b=%0d: probes=%0d result=%0d err=%0d", b, obs_k, result2, err2);
    @(negedge Clk);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_probe8", probe8, 0);
    chk("rst_result8", result8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_err8", err8, 0);
    chk("rst_probe2", probe2, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // b=200: documented probe sequence, done 9 cycles after start
    run8(200, 0, 1'b0);
    model(8, 200);
    cmp_seq("b200");
    chk("b200_lat_const", lat, 9);
    chk("b200_first", obs_p[0], 127);
    fin8("b200", 200, 0);

    // b=255: full DW+1 probes, no overflow error
    run8(255, 0, 1'b0);
    model(8, 255);
    cmp_seq("b255");
    chk("b255_nprobes_const", obs_k, 9);
    fin8("b255", 255, 0);

    // b=0: descends to 0 with no underflow error
    run8(0, 0, 1'b0);
    model(8, 0);
    cmp_seq("b0");
    fin8("b0", 0, 0);

    // Contradictory flags on the 3rd probe
    run8(100, 1, 1'b0);
    chk("both_nprobes", obs_k, 3);
    fin8("both", 0, 1);

    // No flag at all on the 1st probe
    run8(100, 2, 1'b0);
    chk("none_nprobes", obs_k, 1);
    fin8("none", 0, 1);

    // Comparator that always says lt: overflow at probe 255
    run8(0, 3, 1'b0);
    chk("lie_nprobes", obs_k, 9);
    chk("lie_last", obs_p[8], 255);
    fin8("lie", 0, 1);

    // start pulsed mid-search is ignored
    run8(77, 0, 1'b1);
    model(8, 77);
    cmp_seq("poke");
    fin8("poke", 77, 0);

    // Async reset during the 4th probe aborts without done
    @(negedge Clk);
    b8 = 100; mode8 = 0; pidx8 = 1; start8 = 1'b1;
    @(negedge Clk);
    start8 = 1'b0;
    repeat (3) @(negedge Clk);
    chk("abort_busy_before", busy8, 1'b1);
    #2 Rst_n = 1'b0;
    #1;
    chk("abort_probe", probe8, 0);
    chk("abort_result", result8, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_err", err8, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      chk("abort_no_done", done8, 1'b0);
    end
    $display("txn abort: outputs cleared, no done");

    run8(17, 0, 1'b0);
    model(8, 17);
    cmp_seq("b17");
    fin8("b17", 17, 0);

    // Random targets
    for (int t = 0; t < 20; t++) begin
      int b;
      b = int'($urandom_range(255));
      run8(b, 0, 1'b0);
      model(8, b);
      cmp_seq($sformatf("rnd%0d", t));
      chk("rnd_bound", (obs_k <= 9), 1'b1);
      fin8($sformatf("rnd%0d_b%0d", t, b), b, 0);
    end

    // DW=2 exhaustive
    for (int b = 0; b < 4; b++) begin
      run2(b);
      model(2, b);
      cmp_seq($sformatf("dw2_b%0d", b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
